freq_range_ctrl: RTL

Measurement sequencer and auto-ranging controller for the frequency meter. Drives the 2-bit gate-source select of the gate-clock multiplexer (1 Hz / 10 Hz / 100 Hz / 1 kHz reference) and sequences each measurement: clear counter, open gate for one reference period, latch result. In auto mode it moves the range up on counter overflow and down on a leading-zero reading. It sits between the reference mux output, the BCD count chain and the display latch.

---
 rtl/freq_range_ctrl.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/freq_range_ctrl.sv
// Frequency-meter measurement sequencer with auto-ranging of the gate reference.
// Sequences clear / gate / latch and steps the range up on overflow, down on repeated leading-zero readings.
module freq_range_ctrl #(
    parameter int unsigned TO_W = 24
) (
    input  logic       CP,
    input  logic       nCR,
    input  logic       Gate_ref,
    input  logic       Auto,
    input  logic [1:0] F_man,
    input  logic       Ovf,
    input  logic       Msd_zero,
    output logic [1:0] F_sel,
    output logic       Clr_cnt,
    output logic       Gate_EN,
    output logic       Latch,
    output logic       Range_chg,
    output logic       Err
);

    localparam logic [TO_W-1:0] TO_MAX = '1;

    typedef enum logic [1:0] {
        CLEAR     = 2'd0,
        WAIT_RISE = 2'd1,
        GATE      = 2'd2,
        EVAL      = 2'd3
    } state_t;

    state_t          state, state_n;
    logic            s1, s2, s3;
    logic            rise;
    logic [TO_W-1:0] to_cnt, to_cnt_n;
    logic            ovf_seen, ovf_seen_n;
    logic            dn_pend, dn_pend_n;
    logic [1:0]      f_sel_n;
    logic            clr_n, gate_n, latch_n, rchg_n, err_n;
    logic            timeout;

    // Reference edge detect after a two-flop synchronizer.
    assign rise    = s2 & ~s3;
    assign timeout = (to_cnt == TO_MAX);

    always_ff @(posedge CP or negedge nCR) begin
        if (!nCR) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= Gate_ref;
            s2 <= s1;
            s3 <= s2;
        end
    end

    always_ff @(posedge CP or negedge nCR) begin
        if (!nCR) begin
            state     <= CLEAR;
            to_cnt    <= '0;
            ovf_seen  <= 1'b0;
            dn_pend   <= 1'b0;
            F_sel     <= 2'd0;
            Clr_cnt   <= 1'b0;
            Gate_EN   <= 1'b0;
            Latch     <= 1'b0;
            Range_chg <= 1'b0;
            Err       <= 1'b0;
        end else begin
            state     <= state_n;
            to_cnt    <= to_cnt_n;
            ovf_seen  <= ovf_seen_n;
            dn_pend   <= dn_pend_n;
            F_sel     <= f_sel_n;
            Clr_cnt   <= clr_n;
            Gate_EN   <= gate_n;
            Latch     <= latch_n;
            Range_chg <= rchg_n;
            Err       <= err_n;
        end
    end

    // Next state plus next values of every registered output.
    always_comb begin
        state_n    = state;
        to_cnt_n   = to_cnt;
        ovf_seen_n = ovf_seen;
        dn_pend_n  = dn_pend;
        f_sel_n    = F_sel;
        clr_n      = 1'b0;
        gate_n     = 1'b0;
        latch_n    = 1'b0;
        rchg_n     = 1'b0;
        err_n      = Err;

        case (state)
            CLEAR: begin
                clr_n      = 1'b1;
                ovf_seen_n = 1'b0;
                to_cnt_n   = '0;
                if (!Auto) begin
                    f_sel_n   = F_man;
                    dn_pend_n = 1'b0;
                end
                state_n = WAIT_RISE;
            end
            WAIT_RISE: begin
                if (timeout) begin
                    err_n   = 1'b1;
                    state_n = CLEAR;
                end else if (rise) begin
                    to_cnt_n = '0;
                    state_n  = GATE;
                end else begin
                    to_cnt_n = to_cnt + TO_W'(1);
                end
            end
            GATE: begin
                gate_n     = 1'b1;
                ovf_seen_n = ovf_seen | Ovf;
                if (timeout) begin
                    err_n   = 1'b1;
                    state_n = CLEAR;
                end else if (rise) begin
                    state_n = EVAL;
                end else begin
                    to_cnt_n = to_cnt + TO_W'(1);
                end
            end
            EVAL: begin
                state_n = CLEAR;
                if (Auto && ovf_seen && (F_sel != 2'd3)) begin
                    f_sel_n   = F_sel + 2'd1;
                    rchg_n    = 1'b1;
                    dn_pend_n = 1'b0;
                end else if (Auto && !ovf_seen && Msd_zero && (F_sel != 2'd0) && dn_pend) begin
                    f_sel_n   = F_sel - 2'd1;
                    rchg_n    = 1'b1;
                    dn_pend_n = 1'b0;
                end else if (Auto && !ovf_seen && Msd_zero && (F_sel != 2'd0)) begin
                    // First qualifying low reading only arms the down step.
                    dn_pend_n = 1'b1;
                    latch_n   = 1'b1;
                    err_n     = 1'b0;
                end else begin
                    dn_pend_n = 1'b0;
                    latch_n   = 1'b1;
                    err_n     = 1'b0;
                end
            end
            default: state_n = CLEAR;
        endcase
    end

endmodule
